// File: rtl/axi_sdram_cmd_arbiter_if.sv
// AXI write/read address channels plus the unified SDRAM command port.
// The arbiter takes the slave view; the traffic source and SDRAM engine take the master view.
interface axi_sdram_cmd_arbiter_if;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [3:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic        aw_ready;

  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [11:0] cmd_bytes;
  logic        cmd_done;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_bytes,
    input  cmd_ready, cmd_done
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_bytes,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/axi_sdram_cmd_arbiter.sv
// Round-robin arbiter of AXI AW/AR onto one SDRAM command port, one transaction in flight.
// A grant latches the request, presents it until accepted, then waits for done or a timeout.
module axi_sdram_cmd_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic                      clock,
  input  logic                      reset,
  axi_sdram_cmd_arbiter_if.slave    bus,
  output logic                      timeout_err,
  output logic [15:0]               wr_grant_cnt,
  output logic [15:0]               rd_grant_cnt
);
  typedef enum logic [1:0] {IDLE, CMD, BUSY} state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        prio;
  logic [9:0]  timer;
  logic        grant_w, grant_r, expire;
  req_t        aw_req, ar_req, sel, cmd_q;
  logic        cmd_write_q;
  logic [4:0]  beats;
  logic [11:0] bytes_nxt, bytes_q;
  logic [15:0] wr_cnt, rd_cnt;

  assign aw_req = {bus.aw_id, bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst};
  assign ar_req = {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst};

  always_comb begin
    state_nxt = state;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        // prio = 0 favours read, 1 favours write; a lone request always wins
        grant_r = bus.ar_valid && (!bus.aw_valid || !prio);
        grant_w = bus.aw_valid && (!bus.ar_valid ||  prio);
        if (grant_r || grant_w) state_nxt = CMD;
      end
      CMD: begin
        if (bus.cmd_ready) state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.cmd_done) begin
          state_nxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.aw_ready = reset && grant_w;
  assign bus.ar_ready = reset && grant_r;

  // Byte count is registered at grant time so it reads zero out of reset.
  assign sel       = grant_w ? aw_req : ar_req;
  assign beats     = {1'b0, sel.len} + 5'd1;
  assign bytes_nxt = {7'd0, beats} << sel.size;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prio        <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
      cmd_q       <= '0;
      cmd_write_q <= 1'b0;
      bytes_q     <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
    end else begin
      timeout_err <= expire;
      timer       <= (state == BUSY) ? timer + 10'd1 : 10'd0;
      if (grant_w || grant_r) begin
        cmd_q       <= sel;
        cmd_write_q <= grant_w;
        bytes_q     <= bytes_nxt;
        prio        <= grant_r;
        if (grant_w) wr_cnt <= wr_cnt + 16'd1;
        else         rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  assign bus.cmd_valid = (state == CMD);
  assign bus.cmd_write = cmd_write_q;
  assign bus.cmd_id    = cmd_q.id;
  assign bus.cmd_addr  = cmd_q.addr;
  assign bus.cmd_len   = cmd_q.len;
  assign bus.cmd_size  = cmd_q.size;
  assign bus.cmd_burst = cmd_q.burst;
  assign bus.cmd_bytes = bytes_q;

  assign wr_grant_cnt = wr_cnt;
  assign rd_grant_cnt = rd_cnt;
endmodule
